// File: rtl/pblaze_prog_loader.sv
// -----------------------------------------------------------------------------
// pblaze_prog_loader
//
// In-system loader for the 1024x18 KCPSM3 program memory. It sits on the
// program memory address/write port. In normal operation the processor fetch
// address is passed straight through. On a load request, the loader:
//   - holds the processor in reset,
//   - receives a big-endian byte stream (3 bytes per 18-bit word),
//   - writes each word to the memory,
//   - releases the processor after a hold period.
//
// Optional feature macro: PBLAZE_LOADER_CHECKSUM_EN
//   When defined, one extra checksum byte is accepted after the last word.
//   The load succeeds only if the byte sum of the whole stream is 0 mod 256.
//
// Parameters:
//   HOLD_CYCLES     cycles spent in the pre- and post-load hold states (1-15)
//
// Ports:
//   i_clk           clock
//   i_rst           synchronous active-high reset
//   i_cpu_address   processor fetch address
//   o_mem_address   program memory address (pass-through in idle)
//   o_mem_di        program memory write data
//   o_mem_we        program memory write enable, one cycle per word
//   o_cpu_reset     processor reset request
//   i_load_start    one-cycle load request
//   i_load_len      word count (1-1024), sampled with i_load_start
//   i_s_data        host byte
//   i_s_valid       host byte valid
//   o_s_ready       loader accepts a byte
//   o_busy          load in progress
//   o_done          one-cycle pulse on successful completion
//   o_err           sticky error flag
// -----------------------------------------------------------------------------
module pblaze_prog_loader #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [9:0]  i_cpu_address,
    output logic [9:0]  o_mem_address,
    output logic [17:0] o_mem_di,
    output logic        o_mem_we,
    output logic        o_cpu_reset,
    input  logic        i_load_start,
    input  logic [10:0] i_load_len,
    input  logic [7:0]  i_s_data,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

`ifdef PBLAZE_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle,
        StPreHold,
        StB0,
        StB1,
        StB2,
        StWrite,
        StCsum,
        StPostHold
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StPreHold,
        StB0,
        StB1,
        StB2,
        StWrite,
        StPostHold
    } state_e;
`endif

    // Hold counters load HOLD_CYCLES-1 and leave their state on reaching zero.
    localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

    state_e      r_state;
    logic [10:0] r_len;
    logic [9:0]  r_ptr;
    logic [3:0]  r_hold_cnt;
    logic [1:0]  r_word_hi;
    logic [7:0]  r_word_mid;
    logic [9:0]  r_mem_addr;
    logic [17:0] r_mem_di;
    logic        r_mem_we;
    logic        r_cpu_reset;
    logic        r_s_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic        w_last;
    logic        w_len_ok;

`ifdef PBLAZE_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
    logic [7:0]  w_csum_next;

    assign w_csum_next = r_csum + i_s_data;
`endif

    assign w_accept = i_s_valid & r_s_ready;
    // r_ptr is the address just written; compare in 11 bits so a 1024-word
    // load ends at pointer 1023 without wrapping.
    assign w_last   = (({1'b0, r_ptr} + 11'd1) == r_len);
    assign w_len_ok = (i_load_len != 11'd0) && (i_load_len <= 11'd1024);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_len       <= 11'd0;
            r_ptr       <= 10'd0;
            r_hold_cnt  <= 4'd0;
            r_word_hi   <= 2'd0;
            r_word_mid  <= 8'd0;
            r_mem_addr  <= 10'd0;
            r_mem_di    <= 18'd0;
            r_mem_we    <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_s_ready   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef PBLAZE_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_done   <= 1'b0;
            r_mem_we <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (i_load_start) begin
                        if (w_len_ok) begin
                            r_len       <= i_load_len;
                            r_ptr       <= 10'd0;
                            r_mem_addr  <= 10'd0;
                            r_err       <= 1'b0;
                            r_cpu_reset <= 1'b1;
                            r_busy      <= 1'b1;
                            r_hold_cnt  <= HoldLast;
`ifdef PBLAZE_LOADER_CHECKSUM_EN
                            r_csum      <= 8'd0;
`endif
                            r_state     <= StPreHold;
                        end else begin
                            // Illegal length: flag it, leave cpu_reset alone.
                            r_err <= 1'b1;
                        end
                    end
                end

                StPreHold: begin
                    if (r_hold_cnt == 4'd0) begin
                        r_s_ready <= 1'b1;
                        r_state   <= StB0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 4'd1;
                    end
                end

                StB0: begin
                    if (w_accept) begin
                        if (i_s_data[7:2] != 6'd0) begin
                            // Malformed top byte: abort without writing.
                            r_err      <= 1'b1;
                            r_s_ready  <= 1'b0;
                            r_hold_cnt <= HoldLast;
                            r_state    <= StPostHold;
                        end else begin
                            r_word_hi <= i_s_data[1:0];
`ifdef PBLAZE_LOADER_CHECKSUM_EN
                            r_csum    <= w_csum_next;
`endif
                            r_state   <= StB1;
                        end
                    end
                end

                StB1: begin
                    if (w_accept) begin
                        r_word_mid <= i_s_data;
`ifdef PBLAZE_LOADER_CHECKSUM_EN
                        r_csum     <= w_csum_next;
`endif
                        r_state    <= StB2;
                    end
                end

                StB2: begin
                    if (w_accept) begin
                        // Write port registers are loaded here so they are
                        // valid throughout the WRITE cycle.
                        r_mem_di   <= {r_word_hi, r_word_mid, i_s_data};
                        r_mem_addr <= r_ptr;
                        r_mem_we   <= 1'b1;
                        r_s_ready  <= 1'b0;
`ifdef PBLAZE_LOADER_CHECKSUM_EN
                        r_csum     <= w_csum_next;
`endif
                        r_state    <= StWrite;
                    end
                end

                StWrite: begin
                    if (w_last) begin
`ifdef PBLAZE_LOADER_CHECKSUM_EN
                        r_s_ready  <= 1'b1;
                        r_state    <= StCsum;
`else
                        r_hold_cnt <= HoldLast;
                        r_state    <= StPostHold;
`endif
                    end else begin
                        r_ptr     <= r_ptr + 10'd1;
                        r_s_ready <= 1'b1;
                        r_state   <= StB0;
                    end
                end

`ifdef PBLAZE_LOADER_CHECKSUM_EN
                StCsum: begin
                    if (w_accept) begin
                        // Stream sum including this byte must be 0 mod 256.
                        if (w_csum_next != 8'd0) begin
                            r_err <= 1'b1;
                        end
                        r_s_ready  <= 1'b0;
                        r_hold_cnt <= HoldLast;
                        r_state    <= StPostHold;
                    end
                end
`endif

                StPostHold: begin
                    if (r_hold_cnt == 4'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                        // A failed load keeps the processor in reset.
                        if (!r_err) begin
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 4'd1;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_mem_address = (r_state == StIdle) ? i_cpu_address : r_mem_addr;
    assign o_mem_di      = r_mem_di;
    assign o_mem_we      = r_mem_we;
    assign o_cpu_reset   = r_cpu_reset;
    assign o_s_ready     = r_s_ready;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;

endmodule

// File: tb/tb_pblaze_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_pblaze_prog_loader
//
// Bench for pblaze_prog_loader: table of idle/illegal-length vectors, an
// address sweep, hand-written good/bad/abort loads, a full 1024-word load
// with ragged s_valid, and a reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_pblaze_prog_loader;

    localparam int unsigned HOLD = 4;
`ifdef PBLAZE_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cpu_address;
    logic [9:0]  mem_address;
    logic [17:0] mem_di;
    logic        mem_we;
    logic        cpu_reset;
    logic        load_start;
    logic [10:0] load_len;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    pblaze_prog_loader #(
        .HOLD_CYCLES(HOLD)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cpu_address(cpu_address),
        .o_mem_address(mem_address),
        .o_mem_di     (mem_di),
        .o_mem_we     (mem_we),
        .o_cpu_reset  (cpu_reset),
        .i_load_start (load_start),
        .i_load_len   (load_len),
        .i_s_data     (s_data),
        .i_s_valid    (s_valid),
        .o_s_ready    (s_ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor: memory model and event counters ----------------
    int          cyc = 0;
    logic [17:0] tbmem   [0:1023];
    logic [17:0] exp_word[0:1023];
    logic [7:0]  stream  [0:3199];
    logic [9:0]  wr_addr [0:1];
    logic [17:0] wr_data [0:1];
    logic [9:0]  last_wr_addr;
    int wr_cnt, done_cnt, rst_cycles, start_cyc, done_cyc, bad_order;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            tbmem[mem_address] = mem_di;
            if (wr_cnt < 2) begin
                wr_addr[wr_cnt] = mem_address;
                wr_data[wr_cnt] = mem_di;
            end
            if (int'(mem_address) != wr_cnt) bad_order++;
            last_wr_addr = mem_address;
            wr_cnt++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cpu_reset === 1'b1) rst_cycles++;
        if (load_start && !busy) start_cyc = cyc;
    end

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; rst_cycles = 0; bad_order = 0;
        start_cyc = 0; done_cyc = 0; last_wr_addr = 10'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [10:0] len);
        load_len   = len;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Presents stream[0..n-1]; a byte advances only on a seen handshake.
    task automatic feed(input int n, input bit rnd, input int budget);
        int cnt = 0;
        int fed = 0;
        bit hs;
        s_data  = stream[0];
        s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (fed < n && cnt < budget) begin
            @(negedge clk);
            hs = s_valid && s_ready;
            tick();
            cnt++;
            if (hs) fed++;
            if (fed < n) begin
                s_data  = stream[fed];
                s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        if (fed < n) check("feed_timeout", 64'(fed), 64'(n));
    endtask

    task automatic wait_idle(input int budget);
        int cnt = 0;
        while (busy && cnt < budget) begin
            tick();
            cnt++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
    endtask

    // Two-word stream 02 34 56 / 00 AB CD; byte sum is 0x04, so 0xFC balances it.
    task automatic small_load(input logic [7:0] csum_byte);
        stream[0] = 8'h02; stream[1] = 8'h34; stream[2] = 8'h56;
        stream[3] = 8'h00; stream[4] = 8'hAB; stream[5] = 8'hCD;
        stream[6] = csum_byte;
        clear_mon();
        start_load(11'd2);
        feed(6 + CS, 1'b0, 200);
        wait_idle(200);
    endtask

    typedef struct {
        logic [9:0]  addr;
        logic        ls;
        logic [10:0] len;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mism;
        logic [7:0] sum;

        vecs[0] = '{addr: 10'h000, ls: 1'b0, len: 11'd0,    exp_err: 1'b0};
        vecs[1] = '{addr: 10'h155, ls: 1'b0, len: 11'd5,    exp_err: 1'b0};
        vecs[2] = '{addr: 10'h2AA, ls: 1'b0, len: 11'd0,    exp_err: 1'b0};
        vecs[3] = '{addr: 10'h3FF, ls: 1'b0, len: 11'd0,    exp_err: 1'b0};
        vecs[4] = '{addr: 10'h123, ls: 1'b1, len: 11'd0,    exp_err: 1'b1};
        vecs[5] = '{addr: 10'h001, ls: 1'b0, len: 11'd0,    exp_err: 1'b1};
        vecs[6] = '{addr: 10'h200, ls: 1'b1, len: 11'd1025, exp_err: 1'b1};
        vecs[7] = '{addr: 10'h0F0, ls: 1'b1, len: 11'd2047, exp_err: 1'b1};

        for (int i = 0; i < 1024; i++) tbmem[i] = 18'd0;
        clear_mon();
        rst = 1'b1; cpu_address = 10'd0; load_start = 1'b0; load_len = 11'd0;
        s_data = 8'd0; s_valid = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("reset_ctrl", {cpu_reset, busy, done, err, s_ready, mem_we}, 6'b0);
        check("reset_mem_di", mem_di, 18'd0);
        check("reset_addr_pass", mem_address, 10'd0);
        rst = 1'b0;
        tick();

        // Idle pass-through and illegal lengths.
        for (int i = 0; i < 8; i++) begin
            cpu_address = vecs[i].addr;
            load_start  = vecs[i].ls;
            load_len    = vecs[i].len;
            tick();
            check($sformatf("vec%0d", i), {mem_address, err, busy, cpu_reset, mem_we},
                  {vecs[i].addr, vecs[i].exp_err, 3'b000});
            load_start = 1'b0;
        end

        // Same-cycle address sweep.
        mism = 0;
        for (int a = 0; a < 1024; a++) begin
            cpu_address = 10'(a);
            #1;
            if (mem_address !== 10'(a) || mem_we !== 1'b0 || cpu_reset !== 1'b0) mism++;
        end
        check("sweep", 64'(mism), 64'd0);

        // Good two-word load at minimum latency.
        small_load(8'hFC);
        check("small_wr_cnt", 64'(wr_cnt), 64'd2);
        check("small_wr0", {wr_addr[0], wr_data[0]}, {10'd0, 18'h23456});
        check("small_wr1", {wr_addr[1], wr_data[1]}, {10'd1, 18'h0ABCD});
        check("small_done", 64'(done_cnt), 64'd1);
        check("small_latency", 64'(done_cyc - start_cyc), 64'(1 + 2 * HOLD + 8 + CS));
        // cpu_reset falls in the cycle done pulses.
        check("small_rst_cycles", 64'(rst_cycles), 64'(2 * HOLD + 8 + CS));
        check("small_end", {err, cpu_reset, busy}, 3'b000);

`ifdef PBLAZE_LOADER_CHECKSUM_EN
        // Bad checksum keeps the processor in reset; a good load recovers.
        small_load(8'hFD);
        check("badcs_state", {err, cpu_reset, busy}, 3'b110);
        check("badcs_done", 64'(done_cnt), 64'd0);
        small_load(8'hFC);
        check("recover_state", {err, cpu_reset}, 2'b00);
        check("recover_done", 64'(done_cnt), 64'd1);
`endif

        // Malformed B0 byte aborts the load.
        stream[0] = 8'h04;
        clear_mon();
        start_load(11'd2);
        feed(1, 1'b0, 200);
        wait_idle(200);
        check("abort_state", {err, cpu_reset, busy}, 3'b110);
        check("abort_writes", 64'(wr_cnt), 64'd0);
        check("abort_done", 64'(done_cnt), 64'd0);

        // Full 1024-word load with ragged s_valid.
        sum = 8'd0;
        for (int w = 0; w < 1024; w++) begin
            exp_word[w]     = 18'($urandom);
            stream[3 * w]     = {6'd0, exp_word[w][17:16]};
            stream[3 * w + 1] = exp_word[w][15:8];
            stream[3 * w + 2] = exp_word[w][7:0];
            sum = sum + stream[3 * w] + stream[3 * w + 1] + stream[3 * w + 2];
        end
        stream[3072] = 8'(8'd0 - sum);
        clear_mon();
        start_load(11'd1024);
        feed(3072 + CS, 1'b1, 40000);
        wait_idle(200);
        check("full_wr_cnt", 64'(wr_cnt), 64'd1024);
        check("full_last_addr", last_wr_addr, 10'h3FF);
        check("full_order", 64'(bad_order), 64'd0);
        check("full_done", 64'(done_cnt), 64'd1);
        check("full_end", {err, cpu_reset, busy}, 3'b000);
        mism = 0;
        for (int a = 0; a < 1024; a++) begin
            cpu_address = 10'(a);
            #1;
            if (mem_address !== 10'(a) || tbmem[mem_address] !== exp_word[a]) mism++;
        end
        check("readback", 64'(mism), 64'd0);

        // Reset in the middle of a load.
        clear_mon();
        cpu_address = 10'h2C5;
        start_load(11'd1024);
        feed(300, 1'b1, 5000);
        check("midrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst_ctrl", {busy, cpu_reset, done, err, s_ready, mem_we}, 6'b0);
        check("midrst_data", {mem_di, mem_address}, {18'd0, 10'h2C5});
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
